led7_scan: RTL and testbench

LED7_SCAN -- requirements
Module: led7_scan

---
 rtl/led7_pkg.sv | 28 ++
 rtl/bin2bcd_seq.sv | 56 +++++
 rtl/led7_scan.sv | 105 ++++++++++
 tb/tb_led7_scan.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led7_pkg.sv
// Shared constants, FSM encoding and the double-dabble step
// for the 4-digit multiplexed 7-segment driver.
package led7_pkg;

  localparam int DIGITS  = 4;
  localparam int BIN_W   = 14;
  localparam int BCD_W   = 16;
  localparam int MAX_VAL = 9999;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

  // One shift-add-3 iteration: bias digits >= 5, then shift in a bit.
  function automatic logic [BCD_W-1:0] dd_step(
    input logic [BCD_W-1:0] b,
    input logic             in
  );
    logic [BCD_W-1:0] a;
    for (int i = 0; i < DIGITS; i++) begin
      a[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ?
                    b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return {a[BCD_W-2:0], in};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per cycle.
// bcd is valid in the cycle done is high.
module bin2bcd_seq
  import led7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic             busy_q, busy_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [BCD_W-1:0] step;

  assign step = dd_step(acc_q, sh_q[BIN_W-1]);
  assign done = busy_q && (cnt_q == 4'(BIN_W-1));
  assign bcd  = step;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    acc_d  = acc_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      sh_d   = bin;
      acc_d  = '0;
    end else if (busy_q) begin
      acc_d = step;
      sh_d  = {sh_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/led7_scan.sv
// Load/convert control plus multiplexed digit scan with
// leading-zero blanking and overflow blanking.
module led7_scan
  import led7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [BIN_W-1:0] bin_in,
  output logic             load_ready,
  input  logic             blank_lz,
  output logic [3:0]       digit_en,
  output logic [3:0]       bcd_out,
  output logic             seg_enable,
  output logic             ovf
);

  localparam logic [19:0] DIV_M1 = 20'(REFRESH_DIV - 1);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             pend_q, pend_d;
  logic [19:0]      pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;

  logic             accept;
  logic             done;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] upper;
  logic             lz;

  assign load_ready = (state_q == IDLE);
  assign accept     = load_valid && load_ready;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (bin_in),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CONVERT;
          pend_d  = bin_in > BIN_W'(MAX_VAL);
        end
      end
      CONVERT: begin
        if (done) begin
          state_d = IDLE;
          disp_d  = bcd;
          ovf_d   = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d = pre_q + 20'd1;
    idx_d = idx_q;
    if (pre_q >= DIV_M1) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
    end
  end

  // A digit is a leading zero when it and all higher digits are 0.
  assign upper      = disp_q >> {idx_q, 2'b00};
  assign lz         = blank_lz && (idx_q != 2'd0) && (upper == '0);
  assign seg_enable = !ovf_q && !lz;
  assign digit_en   = ~(4'b0001 << idx_q);
  assign bcd_out    = disp_q[{idx_q, 2'b00} +: 4];
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_led7_scan.sv
// Self-checking bench for led7_scan with REFRESH_DIV=4.
// Expected displays are queued at load and compared after update.
module tb_led7_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [13:0] bin_in = '0;
  logic        blank_lz = 1'b0;
  logic        load_ready;
  logic [3:0]  digit_en;
  logic [3:0]  bcd_out;
  logic        seg_enable;
  logic        ovf;

  led7_scan #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .bin_in     (bin_in),
    .load_ready (load_ready),
    .blank_lz   (blank_lz),
    .digit_en   (digit_en),
    .bcd_out    (bcd_out),
    .seg_enable (seg_enable),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          v;
    bit          blank;
    logic [15:0] eb;
    bit          eo;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];
  vec_t sb[$];
  int   den[4] = '{14, 13, 11, 7};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int ndig(input int v);
    int n = 1;
    int x = v;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return n;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_load_ready"}, int'(load_ready), 1);
    chk({tag, "_digit_en"}, int'(digit_en), 14);
    chk({tag, "_bcd_out"}, int'(bcd_out), 0);
    chk({tag, "_seg_enable"}, int'(seg_enable), 1);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  task automatic scan_check(input vec_t e, input int n);
    int idx;
    int es;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      case (digit_en)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      chk("digit_en_legal", int'(idx >= 0), 1);
      if (idx >= 0) begin
        chk($sformatf("ovf_v%0d", e.v), int'(ovf), int'(e.eo));
        es = (!e.eo && !(e.blank && idx > 0 && idx >= ndig(e.v))) ? 1 : 0;
        chk($sformatf("seg_enable_v%0d_d%0d", e.v, idx),
            int'(seg_enable), es);
        if (!e.eo)
          chk($sformatf("bcd_out_v%0d_d%0d", e.v, idx),
              int'(bcd_out), int'(e.eb[4*idx +: 4]));
      end
    end
  endtask

  task automatic wait_ready(input int maxc);
    bit got = 1'b0;
    for (int c = 0; c < maxc && !got; c++) begin
      @(posedge clk);
      #1;
      if (load_ready) got = 1'b1;
    end
    chk("ready_timeout", int'(got), 1);
  endtask

  task automatic conv_window();
    for (int j = 1; j <= 14; j++) begin
      @(posedge clk);
      #1;
      if (j < 14) chk($sformatf("ready_low_%0d", j), int'(load_ready), 0);
      else        chk("ready_back", int'(load_ready), 1);
    end
  endtask

  task automatic do_load(input vec_t e);
    if (!load_ready) wait_ready(40);
    blank_lz   = e.blank;
    load_valid = 1'b1;
    bin_in     = 14'(e.v);
    @(posedge clk);
    sb.push_back(e);
    #1 load_valid = 1'b0;
    conv_window();
  endtask

  task automatic pop_check(input int n);
    vec_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      scan_check(e, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    vec_t zero_v;
    vecs[0] = '{1234,  1'b0, 16'h1234, 1'b0};
    vecs[1] = '{7,     1'b1, 16'h0007, 1'b0};
    vecs[2] = '{1005,  1'b1, 16'h1005, 1'b0};
    vecs[3] = '{10000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{9999,  1'b0, 16'h9999, 1'b0};
    vecs[5] = '{0,     1'b1, 16'h0000, 1'b0};
    vecs[6] = '{100,   1'b1, 16'h0100, 1'b0};
    vecs[7] = '{16383, 1'b1, 16'h0000, 1'b1};
    vecs[8] = '{50,    1'b0, 16'h0050, 1'b0};
    vecs[9] = '{3,     1'b1, 16'h0003, 1'b0};
    zero_v  = '{0,     1'b0, 16'h0000, 1'b0};

    #12;
    chk_reset_outs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      chk($sformatf("idle_digit_en_%0d", n), int'(digit_en), den[(n/4)%4]);
      chk("idle_bcd_out", int'(bcd_out), 0);
      chk("idle_seg_enable", int'(seg_enable), 1);
    end

    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i]);
      pop_check(16);
    end

    blank_lz   = 1'b0;
    load_valid = 1'b1;
    bin_in     = 14'd42;
    @(posedge clk);
    sb.push_back('{42, 1'b0, 16'h0042, 1'b0});
    #1 bin_in = 14'd77;
    conv_window();
    e = sb.pop_front();
    scan_check(e, 1);
    @(posedge clk);
    sb.push_back('{77, 1'b0, 16'h0077, 1'b0});
    #1 load_valid = 1'b0;
    chk("held_accept", int'(load_ready), 0);
    scan_check(e, 12);
    wait_ready(10);
    pop_check(16);

    do_load('{5555, 1'b0, 16'h5555, 1'b0});
    pop_check(16);
    load_valid = 1'b1;
    bin_in     = 14'd321;
    @(posedge clk);
    #1 load_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    scan_check(zero_v, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
